// File: rtl/nbload_tag_ctl_pkg.sv
// nbload_tag_ctl_pkg: shared types and default sizing for the non-blocking load tag controller.
package nbload_tag_ctl_pkg;
   localparam int NBLOAD_NUM   = 4;
   localparam int NBLOAD_TAG_W = 2;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      KILLED = 2'd2
   } nbload_state_t;
   typedef struct packed {
      logic                    valid;
      logic                    wb;
      logic [NBLOAD_TAG_W-1:0] tag;
      logic [4:0]              rd;
   } load_cam_pkt_t;
endpackage

// File: rtl/nbload_tag_ctl_if.sv
// nbload_tag_ctl_if: allocation, return, cancel, scoreboard-check and load-CAM signals of the tag controller.
interface nbload_tag_ctl_if
   import nbload_tag_ctl_pkg::*;
#(parameter int TAG_W = NBLOAD_TAG_W);
   logic             alloc_req;
   logic [4:0]       alloc_rd;
   logic             alloc_gnt;
   logic [TAG_W-1:0] alloc_tag;
   logic             ret_valid;
   logic [TAG_W-1:0] ret_tag;
   logic             ret_err;
   logic             cancel_valid;
   logic [TAG_W-1:0] cancel_tag;
   logic [4:0]       chk_rd;
   logic             chk_hit;
   logic             cam_valid;
   logic             cam_wb;
   logic [TAG_W-1:0] cam_tag;
   logic [4:0]       cam_rd;
   logic             cam_err;
   logic             full;
   logic             empty;
   logic [TAG_W:0]   outstanding;
   logic             unexp_ret;
   modport master (
      output alloc_req, alloc_rd, ret_valid, ret_tag, ret_err, cancel_valid, cancel_tag, chk_rd,
      input  alloc_gnt, alloc_tag, chk_hit, cam_valid, cam_wb, cam_tag, cam_rd, cam_err,
             full, empty, outstanding, unexp_ret
   );
   modport slave (
      input  alloc_req, alloc_rd, ret_valid, ret_tag, ret_err, cancel_valid, cancel_tag, chk_rd,
      output alloc_gnt, alloc_tag, chk_hit, cam_valid, cam_wb, cam_tag, cam_rd, cam_err,
             full, empty, outstanding, unexp_ret
   );
endinterface

// File: rtl/nbload_tag_ctl_entry.sv
// nbload_tag_entry: one load-buffer tag, holding its IDLE/PEND/KILLED state and destination rd.
module nbload_tag_entry
   import nbload_tag_ctl_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          alloc_hit,
   input  logic [4:0]    alloc_rd,
   input  logic          waw_kill,
   input  logic          cancel_hit,
   input  logic          ret_hit,
   output nbload_state_t state,
   output logic [4:0]    rd
);
   nbload_state_t state_d, state_q;
   logic [4:0]    rd_d, rd_q;
   always_comb begin
      rd_d    = alloc_hit ? alloc_rd : rd_q;
      // a load to x0 never writes back, so it starts life already discarded
      state_d = (state_q == IDLE) ? (alloc_hit ? ((alloc_rd == '0) ? KILLED : PEND) : IDLE) :
                ret_hit ? IDLE :
                ((state_q == PEND) && (cancel_hit || waw_kill)) ? KILLED : state_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
      end
   end
   assign state = state_q;
   assign rd    = rd_q;
endmodule

// File: rtl/nbload_tag_ctl.sv
// nbload_tag_ctl: allocates and retires non-blocking load tags, resolves WAW/flush kills
// and emits a registered load-CAM packet on each data return.
module nbload_tag_ctl
   import nbload_tag_ctl_pkg::*;
#(
   parameter int NUM_NBLOAD = NBLOAD_NUM,
   parameter int TAG_W      = NBLOAD_TAG_W
) (
   input logic             clk,
   input logic             rst,
   nbload_tag_ctl_if.slave bus
);
   nbload_state_t         st [NUM_NBLOAD];
   logic [4:0]            rd [NUM_NBLOAD];
   logic [NUM_NBLOAD-1:0] idle, alloc_hit, waw_kill, cancel_hit, ret_hit, pend_hit;
   logic [TAG_W-1:0]      free_tag;
   logic [TAG_W:0]        cnt;
   logic                  ret_live, ret_wb, cam_err_d, cam_err_q, unexp_d, unexp_q;
   load_cam_pkt_t         cam_d, cam_q;
   genvar e;
   for (e = 0; e < NUM_NBLOAD; e++) begin : g_ent
      assign idle[e]       = st[e] == IDLE;
      assign alloc_hit[e]  = bus.alloc_gnt && bus.alloc_tag == TAG_W'(e);
      assign waw_kill[e]   = bus.alloc_gnt && bus.alloc_rd != '0 && st[e] == PEND && rd[e] == bus.alloc_rd;
      assign cancel_hit[e] = bus.cancel_valid && bus.cancel_tag == TAG_W'(e);
      assign ret_hit[e]    = bus.ret_valid && bus.ret_tag == TAG_W'(e) && !idle[e];
      assign pend_hit[e]   = st[e] == PEND && rd[e] == bus.chk_rd;
      nbload_tag_entry u_ent (
         .clk        (clk),
         .rst        (rst),
         .alloc_hit  (alloc_hit[e]),
         .alloc_rd   (bus.alloc_rd),
         .waw_kill   (waw_kill[e]),
         .cancel_hit (cancel_hit[e]),
         .ret_hit    (ret_hit[e]),
         .state      (st[e]),
         .rd         (rd[e])
      );
   end
   always_comb begin
      free_tag = '0;
      cnt      = '0;
      for (int i = NUM_NBLOAD - 1; i >= 0; i--) if (idle[i]) free_tag = TAG_W'(i);
      for (int i = 0; i < NUM_NBLOAD; i++) cnt = cnt + {{TAG_W{1'b0}}, !idle[i]};
      ret_live  = |ret_hit;
      // a same-cycle cancel or younger WAW grant steals the writeback from the returning load
      ret_wb    = st[bus.ret_tag] == PEND && !cancel_hit[bus.ret_tag] && !waw_kill[bus.ret_tag];
      cam_d       = '0;
      cam_d.valid = ret_live;
      cam_d.wb    = ret_live && ret_wb;
      cam_d.tag   = ret_live ? bus.ret_tag : '0;
      cam_d.rd    = ret_live ? rd[bus.ret_tag] : '0;
      cam_err_d = ret_live && bus.ret_err;
      unexp_d   = unexp_q || (bus.ret_valid && !ret_live);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cam_q     <= '0;
         cam_err_q <= 1'b0;
         unexp_q   <= 1'b0;
      end else begin
         cam_q     <= cam_d;
         cam_err_q <= cam_err_d;
         unexp_q   <= unexp_d;
      end
   end
   assign bus.full        = ~|idle;
   assign bus.empty       = &idle;
   assign bus.outstanding = cnt;
   assign bus.alloc_gnt   = bus.alloc_req && !bus.full;
   assign bus.alloc_tag   = free_tag;
   assign bus.chk_hit     = bus.chk_rd != '0 && |pend_hit;
   assign bus.cam_valid   = cam_q.valid;
   assign bus.cam_wb      = cam_q.wb;
   assign bus.cam_tag     = cam_q.tag;
   assign bus.cam_rd      = cam_q.rd;
   assign bus.cam_err     = cam_err_q;
   assign bus.unexp_ret   = unexp_q;
   always @(posedge clk) begin
      if (!rst) begin
         assert (bus.outstanding == (TAG_W+1)'($countones(~idle)));
         for (int i = 0; i < NUM_NBLOAD; i++)
            for (int j = i + 1; j < NUM_NBLOAD; j++)
               assert (!(st[i] == PEND && st[j] == PEND && rd[i] == rd[j] && rd[i] != '0));
      end
   end
endmodule
